// File: rtl/fetch_pc_unit.sv
`timescale 1ns/1ps
// fetch_pc_unit
// Instruction-fetch / program-counter stage of the single-cycle WISC-16 CPU.
// The unit alternates between fetching one 16-bit word over a req/rdy
// handshake and presenting that word to the decoder for a single EXEC cycle.
// During EXEC it consumes the decoder's Branch/Halt outputs to choose the
// next PC, or parks the machine in HALTED until the next reset.
module fetch_pc_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic [1:0]  branch,
   input  logic        halt_dec,
   input  logic [2:0]  flags,
   input  logic [15:0] br_reg,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic        hlt
);

   // FETCH waits on memory, EXEC lasts exactly one cycle, HALTED is sticky.
   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      EXEC   = 2'd1,
      HALTED = 2'd2
   } fetchState_t;

   // Decoder Branch encodings; 01 is reserved and behaves as "no branch".
   localparam logic [1:0] BRANCH_B  = 2'b11;
   localparam logic [1:0] BRANCH_BR = 2'b10;

   // Condition codes carried in instr[11:9].
   localparam logic [2:0] CC_NE = 3'b000;
   localparam logic [2:0] CC_EQ = 3'b001;
   localparam logic [2:0] CC_GT = 3'b010;
   localparam logic [2:0] CC_LT = 3'b011;
   localparam logic [2:0] CC_GE = 3'b100;
   localparam logic [2:0] CC_LE = 3'b101;
   localparam logic [2:0] CC_OV = 3'b110;

   fetchState_t r_state;
   fetchState_t w_nextState;

   logic [15:0] r_pc;
   logic [15:0] r_instr;
   logic        r_hlt;

   logic        w_flagZ;
   logic        w_flagV;
   logic        w_flagN;
   logic        w_condTrue;
   logic [15:0] w_pcPlus2;
   logic [15:0] w_branchOffset;
   logic [15:0] w_branchTarget;
   logic [15:0] w_regTarget;
   logic [15:0] w_nextPc;
   logic        w_instrLoad;
   logic        w_execAdvance;
   logic        w_execHalt;

   // Flags arrive packed as {Z,V,N}; name them once so the condition table reads cleanly.
   assign w_flagZ = flags[2];
   assign w_flagV = flags[1];
   assign w_flagN = flags[0];

   // All PC arithmetic is 16-bit and simply wraps, so 16'hFFFE + 2 lands on 16'h0000.
   assign w_pcPlus2 = r_pc + 16'd2;

   // Branch displacement is the 9-bit signed immediate counted in half-words,
   // i.e. sign-extended and shifted left by one to form a byte offset.
   assign w_branchOffset = {{6{r_instr[8]}}, r_instr[8:0], 1'b0};
   assign w_branchTarget = w_pcPlus2 + w_branchOffset;

   // Register-indirect targets are forced even so the PC can never go odd.
   assign w_regTarget = br_reg & 16'hFFFE;

   // Handshake qualifiers shared by the state register and the datapath.
   assign w_instrLoad   = (r_state == FETCH) && imem_rdy;
   assign w_execHalt    = (r_state == EXEC) && halt_dec;
   assign w_execAdvance = (r_state == EXEC) && !halt_dec;

   // State register: reset always wins, even over a same-cycle imem_rdy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: wait for rdy in FETCH, leave EXEC after one cycle, stay halted.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         FETCH: begin
            if (imem_rdy) begin
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            if (halt_dec) begin
               w_nextState = HALTED;
            end else begin
               w_nextState = FETCH;
            end
         end
         HALTED: begin
            w_nextState = HALTED;
         end
         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

   // Output decode: request only while fetching, flag the instruction only in EXEC.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (r_state)
         FETCH: begin
            imem_req = 1'b1;
         end
         EXEC: begin
            instr_valid = 1'b1;
         end
         default: begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
         end
      endcase
   end

   // Condition evaluation on {Z,V,N} for the ccc field of the current instruction.
   always_comb begin
      w_condTrue = 1'b0;
      case (r_instr[11:9])
         CC_NE:   w_condTrue = !w_flagZ;
         CC_EQ:   w_condTrue = w_flagZ;
         CC_GT:   w_condTrue = !w_flagZ && !w_flagN;
         CC_LT:   w_condTrue = w_flagN;
         CC_GE:   w_condTrue = w_flagZ || (!w_flagZ && !w_flagN);
         CC_LE:   w_condTrue = w_flagN || w_flagZ;
         CC_OV:   w_condTrue = w_flagV;
         default: w_condTrue = 1'b1;
      endcase
   end

   // Next-PC select: taken B or BR redirects, everything else falls through to pc+2.
   always_comb begin
      w_nextPc = w_pcPlus2;
      if ((branch == BRANCH_B) && w_condTrue) begin
         w_nextPc = w_branchTarget;
      end else if ((branch == BRANCH_BR) && w_condTrue) begin
         w_nextPc = w_regTarget;
      end
   end

   // PC register: only moves at the end of a non-halting EXEC cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (w_execAdvance) begin
         r_pc <= w_nextPc;
      end
   end

   // Instruction register: captures the memory word on the rdy edge and otherwise holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instr <= 16'h0000;
      end else if (w_instrLoad) begin
         r_instr <= imem_data;
      end
   end

   // Halt flag: set when the decoder reports Halt in EXEC, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hlt <= 1'b0;
      end else if (w_execHalt) begin
         r_hlt <= 1'b1;
      end
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign pc_plus2  = w_pcPlus2;
   assign instr     = r_instr;
   assign hlt       = r_hlt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
`timescale 1ns/1ps
// tb_fetch_pc_unit
// Randomized bench for the fetch/PC stage. The driver plays both instruction
// memory and decoder; a reference model computes the next PC from the
// branch rules, and a monitor checks fetch addresses and EXEC cycles
// against queues of expected values.
module tb_fetch_pc_unit;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic [1:0]  branch;
   logic        halt_dec;
   logic [2:0]  flags;
   logic [15:0] br_reg;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        hlt;

   int vecCount = 0;
   int errCount = 0;

   logic [15:0] fetchQ[$];
   logic [31:0] execQ[$];
   logic [15:0] mPc;
   logic [15:0] mLastInstr;
   logic        mHalted;
   logic        monEn = 1'b0;

   fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rdy(imem_rdy),
      .imem_data(imem_data),
      .instr(instr),
      .instr_valid(instr_valid),
      .branch(branch),
      .halt_dec(halt_dec),
      .flags(flags),
      .br_reg(br_reg),
      .pc(pc),
      .pc_plus2(pc_plus2),
      .hlt(hlt)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check steps both counters.
   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      vecCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   // Reference model: next PC from the architectural branch rules using plain integer math.
   function automatic logic [15:0] modelNext(input logic [15:0] curPc, input logic [15:0] word,
                                            input logic [1:0] br, input logic [2:0] fl,
                                            input logic [15:0] brr);
      bit z, v, n, take;
      int imm;
      int nxt;
      z = fl[2];
      v = fl[1];
      n = fl[0];
      case (word[11:9])
         3'd0:    take = !z;
         3'd1:    take = z;
         3'd2:    take = !z && !n;
         3'd3:    take = n;
         3'd4:    take = z || (!z && !n);
         3'd5:    take = n || z;
         3'd6:    take = v;
         default: take = 1'b1;
      endcase
      imm = int'(word[8:0]);
      if (imm >= 256) imm = imm - 512;
      if (br == 2'b11 && take)      nxt = int'(curPc) + 2 + imm * 2;
      else if (br == 2'b10 && take) nxt = int'(brr) - int'(brr[0]);
      else                          nxt = int'(curPc) + 2;
      nxt = ((nxt % 65536) + 65536) % 65536;
      return 16'(nxt);
   endfunction

   // Monitor: just after each rising edge, check fetch address and any EXEC cycle.
   always @(posedge clk) begin
      logic [31:0] rec;
      logic [15:0] dropped;
      #1;
      if (monEn) begin
         if (instr_valid === 1'b1) begin
            if (execQ.size() == 0) begin
               checkOutput("unexpected exec", {15'b0, instr_valid}, 16'h0000);
            end else begin
               rec = execQ.pop_front();
               checkOutput("exec pc", pc, rec[31:16]);
               checkOutput("exec instr", instr, rec[15:0]);
               checkOutput("exec pc_plus2", pc_plus2, 16'((int'(rec[31:16]) + 2) % 65536));
               checkOutput("exec req low", {15'b0, imem_req}, 16'h0000);
               checkOutput("exec hlt low", {15'b0, hlt}, 16'h0000);
               if (fetchQ.size() > 0) dropped = fetchQ.pop_front();
            end
         end else if (imem_req === 1'b1) begin
            if (fetchQ.size() == 0) begin
               checkOutput("unexpected fetch", {15'b0, imem_req}, 16'h0000);
            end else begin
               checkOutput("fetch addr", imem_addr, fetchQ[0]);
               checkOutput("fetch instr hold", instr, mLastInstr);
            end
         end
      end
   end

   // Reset for one edge, optionally with imem_rdy high at the same edge, then check reset state.
   task automatic doReset(input logic rdyDuring);
      monEn     = 1'b0;
      rst_n     = 1'b0;
      imem_rdy  = rdyDuring;
      imem_data = 16'hBEEF;
      @(negedge clk);
      imem_rdy = 1'b0;
      checkOutput("reset pc", pc, RESET_PC);
      checkOutput("reset instr", instr, 16'h0000);
      checkOutput("reset hlt", {15'b0, hlt}, 16'h0000);
      checkOutput("reset valid", {15'b0, instr_valid}, 16'h0000);
      checkOutput("reset req", {15'b0, imem_req}, 16'h0001);
      fetchQ.delete();
      execQ.delete();
      mPc        = RESET_PC;
      mLastInstr = 16'h0000;
      mHalted    = 1'b0;
      fetchQ.push_back(mPc);
      rst_n = 1'b1;
      monEn = 1'b1;
   endtask

   // One instruction: memory answers after 'lat' cycles, decoder drives its outputs in EXEC.
   task automatic applyStimulus(input logic [15:0] word, input int lat, input logic [1:0] br,
                                input logic hd, input logic [2:0] fl, input logic [15:0] brr);
      checkOutput("fetch req", {15'b0, imem_req}, 16'h0001);
      if (imem_req !== 1'b1) return;
      for (int k = 1; k < lat; k++) begin
         imem_rdy  = 1'b0;
         imem_data = 16'($urandom);
         @(negedge clk);
      end
      imem_rdy   = 1'b1;
      imem_data  = word;
      mLastInstr = word;
      execQ.push_back({mPc, word});
      @(negedge clk);
      imem_rdy  = 1'b0;
      imem_data = 16'($urandom);
      branch    = br;
      halt_dec  = hd;
      flags     = fl;
      br_reg    = brr;
      if (hd) begin
         mHalted = 1'b1;
      end else begin
         mPc = modelNext(mPc, word, br, fl, brr);
         fetchQ.push_back(mPc);
      end
      @(negedge clk);
      branch   = 2'($urandom);
      halt_dec = 1'($urandom);
      flags    = 3'($urandom);
      br_reg   = 16'($urandom);
   endtask

   // While halted, memory noise must not wake the unit and the PC must stay put.
   task automatic checkHalted(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         checkOutput("halt hlt", {15'b0, hlt}, 16'h0001);
         checkOutput("halt req", {15'b0, imem_req}, 16'h0000);
         checkOutput("halt valid", {15'b0, instr_valid}, 16'h0000);
         checkOutput("halt pc", pc, mPc);
         checkOutput("halt instr", instr, mLastInstr);
         imem_rdy  = 1'($urandom);
         imem_data = 16'($urandom);
         @(negedge clk);
      end
      imem_rdy = 1'b0;
   endtask

   // Redirect the PC with an unconditional BR.
   task automatic jumpTo(input logic [15:0] target);
      applyStimulus(16'hDE00, 1, 2'b10, 1'b0, 3'($urandom), target);
   endtask

   // Directed scenarios first, then a randomized instruction stream.
   initial begin
      logic [15:0] word;
      logic [1:0]  br;
      logic        hd;
      int          lat;
      rst_n      = 1'b0;
      imem_rdy   = 1'b0;
      imem_data  = 16'h0000;
      branch     = 2'b00;
      halt_dec   = 1'b0;
      flags      = 3'b000;
      br_reg     = 16'h0000;
      mPc        = RESET_PC;
      mLastInstr = 16'h0000;
      mHalted    = 1'b0;
      @(negedge clk);
      doReset(1'b0);

      $display("[TB] reset and 2-cycle fetch");
      applyStimulus(16'h1123, 2, 2'b00, 1'b0, 3'b000, 16'h0000);

      $display("[TB] B taken / not taken");
      jumpTo(16'h0010);
      applyStimulus(16'hC3FC, 1, 2'b11, 1'b0, 3'b100, 16'h0000);
      checkOutput("B taken pc", pc, 16'h000A);
      jumpTo(16'h0010);
      applyStimulus(16'hC3FC, 3, 2'b11, 1'b0, 3'b000, 16'h0000);
      checkOutput("B not taken pc", pc, 16'h0012);

      $display("[TB] BR and reserved branch code");
      jumpTo(16'h0020);
      applyStimulus(16'hDE00, 2, 2'b10, 1'b0, 3'b000, 16'h1235);
      checkOutput("BR pc", pc, 16'h1234);
      jumpTo(16'h0020);
      applyStimulus(16'hDE00, 1, 2'b01, 1'b0, 3'b111, 16'h1235);
      checkOutput("branch 01 pc", pc, 16'h0022);

      $display("[TB] halt over branch");
      jumpTo(16'h0040);
      applyStimulus(16'hCE05, 1, 2'b11, 1'b1, 3'b000, 16'h0000);
      checkHalted(20);
      checkOutput("halt pc 0040", pc, 16'h0040);

      $display("[TB] reset in halted, then reset mid-fetch");
      doReset(1'b1);
      applyStimulus(16'h2222, 1, 2'b00, 1'b0, 3'b000, 16'h0000);
      jumpTo(16'h0100);
      checkOutput("at 0100", pc, 16'h0100);
      doReset(1'b1);

      $display("[TB] wrap-around");
      jumpTo(16'hFFFE);
      applyStimulus(16'h3333, 1, 2'b00, 1'b0, 3'b000, 16'h0000);
      checkOutput("wrap pc", pc, 16'h0000);
      checkOutput("wrap pc_plus2", pc_plus2, 16'h0002);
      jumpTo(16'hFFFC);
      applyStimulus(16'hCE01, 2, 2'b11, 1'b0, 3'b000, 16'h0000);
      checkOutput("wrap B pc", pc, 16'h0000);

      $display("[TB] random stream");
      for (int i = 0; i < 200; i++) begin
         word = 16'($urandom);
         lat  = $urandom_range(1, 4);
         br   = 2'($urandom);
         hd   = ($urandom_range(0, 15) == 0);
         applyStimulus(word, lat, br, hd, 3'($urandom), 16'($urandom));
         if (hd) begin
            checkHalted(4);
            doReset(1'($urandom));
         end
      end

      repeat (3) @(negedge clk);
      if (execQ.size() != 0) checkOutput("execQ drained", 16'(execQ.size()), 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
